// File: rtl/otter_branch_predictor.sv
// otter_branch_predictor: direct-mapped BTB with saturating direction counters and resolution statistics
module otter_branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      IF_PC,
    output logic             PRED_TAKEN,
    output logic [31:0]      PRED_TARGET,
    input  logic             UPD_VALID,
    input  logic             UPD_COND,
    input  logic [31:0]      UPD_PC,
    input  logic             UPD_TAKEN,
    input  logic [31:0]      UPD_TARGET,
    input  logic             UPD_PRED_TAKEN,
    input  logic [31:0]      UPD_PRED_TGT,
    output logic             MISPREDICT,
    output logic [31:0]      REDIRECT_PC,
    output logic [CNT_W-1:0] BR_CNT,
    output logic [CNT_W-1:0] MISS_CNT
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [29:0]      tgt_q   [ENTRIES];
    logic [CTR_W-1:0] ctr_q   [ENTRIES];

    logic [IDX_W-1:0] if_idx, upd_idx;
    logic [TAG_W-1:0] if_tag, upd_tag;
    logic             if_hit, upd_hit, upd_write, tgt_write;
    logic [CTR_W-1:0] upd_ctr, ctr_nxt;

    assign if_idx  = IF_PC[IDX_W+1:2];
    assign if_tag  = IF_PC[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_idx = UPD_PC[IDX_W+1:2];
    assign upd_tag = UPD_PC[IDX_W+TAG_W+1:IDX_W+2];

    assign if_hit      = valid_q[if_idx] && tag_q[if_idx] == if_tag;
    assign PRED_TAKEN  = if_hit && ctr_q[if_idx][CTR_W-1];
    assign PRED_TARGET = PRED_TAKEN ? {tgt_q[if_idx], 2'b00} : IF_PC + 32'd4;

    assign MISPREDICT  = UPD_VALID && (UPD_TAKEN != UPD_PRED_TAKEN || (UPD_TAKEN && UPD_TARGET != UPD_PRED_TGT));
    assign REDIRECT_PC = UPD_TAKEN ? UPD_TARGET : UPD_PC + 32'd4;

    assign upd_hit = valid_q[upd_idx] && tag_q[upd_idx] == upd_tag;
    assign upd_ctr = ctr_q[upd_idx];

    // Jumps pin the counter high; fresh conditional entries start weakly taken.
    always_comb begin
        ctr_nxt = !UPD_COND ? CTR_MAX :
                  !upd_hit  ? CTR_WT  :
                  UPD_TAKEN ? (upd_ctr == CTR_MAX ? upd_ctr : upd_ctr + 1'b1) :
                              (upd_ctr == '0 ? upd_ctr : upd_ctr - 1'b1);
    end

    assign upd_write = UPD_VALID && (upd_hit || UPD_TAKEN);
    assign tgt_write = UPD_TAKEN || !UPD_COND;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
            BR_CNT   <= '0;
            MISS_CNT <= '0;
        end else begin
            if (upd_write) begin
                valid_q[upd_idx] <= 1'b1;
                tag_q[upd_idx]   <= upd_tag;
                ctr_q[upd_idx]   <= ctr_nxt;
                if (tgt_write) tgt_q[upd_idx] <= UPD_TARGET[31:2];
            end
            if (UPD_VALID && BR_CNT != '1) BR_CNT <= BR_CNT + 1'b1;
            if (MISPREDICT && MISS_CNT != '1) MISS_CNT <= MISS_CNT + 1'b1;
        end
    end
endmodule

// File: tb/tb_otter_branch_predictor.sv
// tb_otter_branch_predictor: directed + random stimulus against an array-based predictor model, scoreboard checked
module tb_otter_branch_predictor;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] IF_PC = 32'h100;
    logic        PRED_TAKEN;
    logic [31:0] PRED_TARGET;
    logic        UPD_VALID = 1'b0, UPD_COND = 1'b0, UPD_TAKEN = 1'b0, UPD_PRED_TAKEN = 1'b0;
    logic [31:0] UPD_PC = '0, UPD_TARGET = '0, UPD_PRED_TGT = '0;
    logic        MISPREDICT;
    logic [31:0] REDIRECT_PC;
    logic [15:0] BR_CNT, MISS_CNT;

    otter_branch_predictor dut (
        .CLK(CLK), .RST(RST), .IF_PC(IF_PC), .PRED_TAKEN(PRED_TAKEN), .PRED_TARGET(PRED_TARGET),
        .UPD_VALID(UPD_VALID), .UPD_COND(UPD_COND), .UPD_PC(UPD_PC), .UPD_TAKEN(UPD_TAKEN),
        .UPD_TARGET(UPD_TARGET), .UPD_PRED_TAKEN(UPD_PRED_TAKEN), .UPD_PRED_TGT(UPD_PRED_TGT),
        .MISPREDICT(MISPREDICT), .REDIRECT_PC(REDIRECT_PC), .BR_CNT(BR_CNT), .MISS_CNT(MISS_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        pt;
        logic [31:0] ptg;
        logic        mis;
        logic [31:0] red;
        logic [15:0] br;
        logic [15:0] miss;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    bit          m_valid [16];
    int          m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    int          m_br, m_miss;

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic int tag_of(logic [31:0] pc);
        return int'((pc >> 6) % 256);
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_valid[idx_of(pc)] && m_tag[idx_of(pc)] == tag_of(pc);
    endfunction

    function automatic bit m_pred(logic [31:0] pc);
        return m_hit(pc) && m_ctr[idx_of(pc)] >= 2;
    endfunction

    function automatic logic [31:0] m_pred_tgt(logic [31:0] pc);
        return m_pred(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i] = 1;
        end
        m_br = 0;
        m_miss = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step(input bit rst, input logic [31:0] ifpc, input bit uv, input bit cond,
                        input logic [31:0] upc, input bit tk, input logic [31:0] tgt,
                        input bit ptk, input logic [31:0] ptg);
        exp_t e;
        bit mis;
        int i;
        @(posedge CLK);
        #1;
        RST = rst; IF_PC = ifpc; UPD_VALID = uv; UPD_COND = cond; UPD_PC = upc;
        UPD_TAKEN = tk; UPD_TARGET = tgt; UPD_PRED_TAKEN = ptk; UPD_PRED_TGT = ptg;
        mis = uv && (tk != ptk || (tk && tgt != ptg));
        e.pt = m_pred(ifpc);
        e.ptg = m_pred_tgt(ifpc);
        e.mis = mis;
        e.red = tk ? tgt : upc + 32'd4;
        e.br = 16'(m_br);
        e.miss = 16'(m_miss);
        q.push_back(e);
        if (!rst) m_reset();
        else if (uv) begin
            m_br = (m_br < 65535) ? m_br + 1 : m_br;
            if (mis) m_miss = (m_miss < 65535) ? m_miss + 1 : m_miss;
            i = idx_of(upc);
            if (m_hit(upc)) begin
                if (!cond) begin
                    m_ctr[i] = 3;
                    m_tgt[i] = tgt & ~32'd3;
                end else if (tk) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = tgt & ~32'd3;
                end else m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end else if (tk) begin
                m_valid[i] = 1'b1;
                m_tag[i] = tag_of(upc);
                m_tgt[i] = tgt & ~32'd3;
                m_ctr[i] = cond ? 2 : 3;
            end
        end
    endtask

    task automatic idle(input logic [31:0] ifpc);
        step(1'b1, ifpc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pred_taken", {31'b0, PRED_TAKEN}, {31'b0, e.pt});
                chk("pred_target", PRED_TARGET, e.ptg);
                chk("mispredict", {31'b0, MISPREDICT}, {31'b0, e.mis});
                chk("redirect_pc", REDIRECT_PC, e.red);
                chk("br_cnt", {16'b0, BR_CNT}, {16'b0, e.br});
                chk("miss_cnt", {16'b0, MISS_CNT}, {16'b0, e.miss});
            end
        end
    end

    initial begin : driver
        logic [31:0] pc, ipc, tg;
        bit cond, tk, ptk;
        int waited;
        m_reset();
        step(1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(32'h100);
        // allocate, then saturate and walk the counter back down
        step(1'b1, 32'h100, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
        step(1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
        step(1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
        step(1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
        step(1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
        step(1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
        idle(32'h40);
        // alias at the same index evicts the 0x40 entry
        step(1'b1, 32'h40, 1'b1, 1'b0, 32'h440, 1'b1, 32'h200, 1'b0, 32'h444);
        idle(32'h40);
        idle(32'h440);
        // same-cycle lookup and allocation, then mid-op reset
        step(1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
        idle(32'h40);
        step(1'b0, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
        idle(32'h40);
        idle(32'hFFFF_FFFC);
        for (int n = 0; n < 3000; n++) begin
            pc  = ($urandom_range(0, 3) == 0) ? ($urandom & ~32'd3)
                  : (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 3)) << 2);
            ipc = ($urandom_range(0, 3) == 0) ? pc
                  : ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC
                  : (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 3)) << 2);
            cond = $urandom_range(0, 3) != 0;
            tk   = cond ? $urandom_range(0, 1) == 1 : 1'b1;
            tg   = ($urandom_range(0, 1) == 1) ? (32'($urandom_range(0, 7)) << 4) : $urandom;
            ptk  = ($urandom_range(0, 4) == 0) ? 1'($urandom_range(0, 1)) : m_pred(pc);
            step($urandom_range(0, 99) != 0, ipc, $urandom_range(0, 4) != 0, cond, pc, tk, tg,
                 ptk, ($urandom_range(0, 4) == 0) ? $urandom : m_pred_tgt(pc));
        end
        idle(32'h0);
        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(posedge CLK);
            waited++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", q.size());
        end
        @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
